disp_sel_arbiter: RTL and testbench

//  Shares the Genius 7-segment display path between two requesters, e.g. game pattern and score.

---
 rtl/disp_sel_arbiter_pkg.sv | 23 ++
 rtl/disp_sel_arbiter_mux2x1.sv | 16 +
 rtl/disp_sel_arbiter.sv | 101 ++++++++++
 tb/tb_disp_sel_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/disp_sel_arbiter_pkg.sv
// Shared definitions for the display-select arbiter: state encodings,
// default pattern width/blank value and the grant decode helper.
package disp_sel_arbiter_pkg;

  localparam int unsigned SEG_WIDTH = 7;
  localparam logic [SEG_WIDTH-1:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN0 = 2'b01,
    ST_OWN1 = 2'b10
  } arb_state_t;

  // One-hot {gnt1,gnt0} for a given owner state; anything else grants nobody.
  function automatic logic [1:0] gnt_decode(input arb_state_t st);
    case (st)
      ST_OWN0: gnt_decode = 2'b01;
      ST_OWN1: gnt_decode = 2'b10;
      default: gnt_decode = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/disp_sel_arbiter_mux2x1.sv
// Plain 2:1 pattern mux feeding the display output register.
module mux2x1 #(
  parameter int unsigned WIDTH = 7
) (
  input  logic [WIDTH-1:0] ENT0_i,
  input  logic [WIDTH-1:0] ENT1_i,
  input  logic             SEL_i,
  output logic [WIDTH-1:0] OUT_o
);

  // Select requester 1's pattern when SEL_i is high.
  always_comb begin
    OUT_o = SEL_i ? ENT1_i : ENT0_i;
  end

endmodule

// File: rtl/disp_sel_arbiter.sv
// Round-robin arbiter sharing the 7-segment path between two requesters,
// with a minimum-visibility hold and a maximum-ownership limit.
module disp_sel_arbiter
  import disp_sel_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH       = SEG_WIDTH,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned MAX_CYCLES  = 8,
  parameter logic [WIDTH-1:0] BLANK  = SEG_BLANK
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             req0_i,
  input  logic             req1_i,
  input  logic [WIDTH-1:0] data0_i,
  input  logic [WIDTH-1:0] data1_i,
  output logic [1:0]       gnt_o,
  output logic             sel_o,
  output logic [WIDTH-1:0] seg_o,
  output logic             preempt_o
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_LAST  = CNT_W'(MAX_CYCLES - 1);

  arb_state_t       state, state_nxt, other_st;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             rr_last, rr_nxt;
  logic             pre_nxt;
  logic             mine, other;
  logic [WIDTH-1:0] mux_out;

  mux2x1 #(.WIDTH(WIDTH)) u_mux (
    .ENT0_i (data0_i),
    .ENT1_i (data1_i),
    .SEL_i  (sel_o),
    .OUT_o  (mux_out)
  );

  // Next-state, ownership counter and round-robin pointer.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rr_nxt    = rr_last;
    pre_nxt   = 1'b0;
    mine      = 1'b0;
    other     = 1'b0;
    other_st  = ST_IDLE;
    case (state)
      ST_IDLE: begin
        // rr_last=1 means requester 1 owned last, so requester 0 wins a tie.
        if (req0_i && (!req1_i || rr_last)) state_nxt = ST_OWN0;
        else if (req1_i)                    state_nxt = ST_OWN1;
      end
      ST_OWN0, ST_OWN1: begin
        mine     = (state == ST_OWN0) ? req0_i : req1_i;
        other    = (state == ST_OWN0) ? req1_i : req0_i;
        other_st = (state == ST_OWN0) ? ST_OWN1 : ST_OWN0;
        if (cnt < HOLD_LAST) begin
          cnt_nxt = cnt + 1'b1;
        end else if (!mine) begin
          state_nxt = other ? other_st : ST_IDLE;
        end else if (other && (cnt == MAX_LAST)) begin
          state_nxt = other_st;
          pre_nxt   = 1'b1;
        end else if (cnt != MAX_LAST) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Every change of owner restarts the count and records the new owner.
    if (state_nxt != state) begin
      cnt_nxt = '0;
      if (state_nxt != ST_IDLE) rr_nxt = (state_nxt == ST_OWN1);
    end
  end

  // State, counters and all registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      rr_last   <= 1'b1;
      gnt_o     <= '0;
      sel_o     <= 1'b0;
      seg_o     <= BLANK;
      preempt_o <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rr_last   <= rr_nxt;
      gnt_o     <= gnt_decode(state_nxt);
      sel_o     <= (state_nxt == ST_OWN1);
      seg_o     <= (state == ST_IDLE) ? BLANK : mux_out;
      preempt_o <= pre_nxt;
    end
  end

endmodule

// File: tb/tb_disp_sel_arbiter.sv
// Self-checking bench for disp_sel_arbiter against an owner/age reference model.
module tb_disp_sel_arbiter;

  localparam int HOLD = 4;
  localparam int MAXC = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1;
  logic [6:0] data0, data1;
  logic [1:0] gnt;
  logic       sel;
  logic [6:0] seg;
  logic       preempt;

  int errs   = 0;
  int checks = 0;

  // Reference model: owner (-1 = nobody), cycles owned, last owner.
  int         own, age, last;
  logic [6:0] m_seg;
  logic       m_pre;

  disp_sel_arbiter #(
    .WIDTH       (7),
    .CNT_W       (16),
    .HOLD_CYCLES (HOLD),
    .MAX_CYCLES  (MAXC),
    .BLANK       (7'h00)
  ) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .req0_i    (req0),
    .req1_i    (req1),
    .data0_i   (data0),
    .data1_i   (data1),
    .gnt_o     (gnt),
    .sel_o     (sel),
    .seg_o     (seg),
    .preempt_o (preempt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    own = -1; age = 0; last = 1; m_seg = 7'h00; m_pre = 1'b0;
  endfunction

  // One rising edge of the arbitration rules, applied to the sampled inputs.
  function automatic void model_step(input logic r0, input logic r1,
                                     input logic [6:0] d0, input logic [6:0] d1);
    int  nxt;
    bit  keep_req, rival_req;
    m_seg = (own < 0) ? 7'h00 : ((own == 1) ? d1 : d0);
    m_pre = 1'b0;
    nxt   = own;
    if (own < 0) begin
      if (r0 && r1)  nxt = 1 - last;
      else if (r0)   nxt = 0;
      else if (r1)   nxt = 1;
    end else begin
      keep_req  = (own == 0) ? r0 : r1;
      rival_req = (own == 0) ? r1 : r0;
      if (age + 1 >= HOLD) begin
        if (!keep_req)                          nxt = rival_req ? 1 - own : -1;
        else if (rival_req && age == MAXC - 1) begin nxt = 1 - own; m_pre = 1'b1; end
      end
    end
    if (nxt != own) begin
      age = 0;
      if (nxt >= 0) last = nxt;
    end else if (own >= 0 && age < MAXC - 1) begin
      age++;
    end
    own = nxt;
  endfunction

  task automatic check_all();
    chk("gnt", {14'd0, gnt}, (own < 0) ? 16'd0 : ((own == 0) ? 16'd1 : 16'd2));
    chk("sel", {15'd0, sel}, {15'd0, (own == 1)});
    chk("seg", {9'd0, seg}, {9'd0, m_seg});
    chk("preempt", {15'd0, preempt}, {15'd0, m_pre});
  endtask

  // Drive one cycle from a negedge, let the edge happen, check at the next negedge.
  task automatic drive(input logic r0, input logic r1, input logic [6:0] d0, input logic [6:0] d1);
    req0 = r0; req1 = r1; data0 = d0; data1 = d1;
    @(posedge clk);
    model_step(r0, r1, d0, d1);
    @(negedge clk);
    check_all();
  endtask

  // Asynchronous reset between edges: outputs must clear without a clock.
  task automatic do_reset(input string tag);
    #1 rst_n = 1'b0;
    #1;
    chk({tag, "_gnt"}, {14'd0, gnt}, 16'd0);
    chk({tag, "_sel"}, {15'd0, sel}, 16'd0);
    chk({tag, "_seg"}, {9'd0, seg}, 16'd0);
    chk({tag, "_pre"}, {15'd0, preempt}, 16'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n, idx, pre_seen;
    logic r0, r1;
    model_reset();
    rst_n = 1'b0; req0 = 0; req1 = 0; data0 = '0; data1 = '0;
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Hold: one-cycle request keeps the grant for HOLD cycles.
    n = 0;
    drive(1, 0, 7'h3F, 7'h11);
    n += (gnt == 2'b01);
    repeat (6) begin
      drive(0, 0, 7'h3F, 7'h11);
      n += (gnt == 2'b01);
    end
    chk("hold_len", 16'(n), 16'(HOLD));
    chk("hold_blank", {9'd0, seg}, 16'h00);

    // Tie from reset: requester 0 first, preempted after MAX cycles.
    do_reset("rst_a");
    idx = 0;
    for (int i = 1; i <= 12; i++) begin
      drive(1, 1, 7'h3F, 7'h06);
      if (preempt && idx == 0) idx = i;
    end
    chk("preempt_at", 16'(idx), 16'(MAXC + 1));

    // Round robin: after requester 1 owned, a tie in IDLE goes to 0, then to 1.
    repeat (6) drive(0, 0, 7'h3F, 7'h06);
    drive(1, 1, 7'h22, 7'h44);
    chk("rr_to0", {14'd0, gnt}, 16'd1);
    repeat (6) drive(0, 0, 7'h22, 7'h44);
    drive(1, 1, 7'h22, 7'h44);
    chk("rr_to1", {14'd0, gnt}, 16'd2);

    // Reset while requester 1 owns.
    do_reset("rst_own1");

    // Requester 1 alone never gets preempted.
    pre_seen = 0;
    repeat (20) begin
      drive(0, 1, 7'h01, 7'h5B);
      pre_seen += preempt;
    end
    chk("alone_gnt", {14'd0, gnt}, 16'd2);
    chk("alone_nopre", 16'(pre_seen), 16'd0);
    // Counter saturated: a late rival takes over at the very next edge.
    drive(1, 1, 7'h01, 7'h5B);
    chk("late_rival", {14'd0, gnt}, 16'd1);
    chk("late_pre", {15'd0, preempt}, 16'd1);

    // Rival raised at cycle 3 of requester 1's grant: switch only once count hits MAX-1.
    repeat (10) drive(0, 0, 7'h01, 7'h5B);
    idx = 0;
    for (int i = 1; i <= 12; i++) begin
      drive(i >= 3, 1, 7'h4F, 7'h66);
      if (gnt == 2'b01 && idx == 0) idx = i;
    end
    chk("switch_at", 16'(idx), 16'(MAXC + 1));

    // Early release: owner drops during hold, rival takes over when hold ends.
    do_reset("rst_b");
    idx = 0; pre_seen = 0;
    for (int i = 1; i <= 8; i++) begin
      drive(i <= 2, 1, 7'h6D, 7'h7D);
      pre_seen += preempt;
      if (gnt == 2'b10 && idx == 0) idx = i;
    end
    chk("early_switch", 16'(idx), 16'(HOLD + 1));
    chk("early_nopre", 16'(pre_seen), 16'd0);

    // Random traffic with sticky requests and occasional resets.
    r0 = 0; r1 = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(4, 0) == 0) r0 = ~r0;
      if ($urandom_range(4, 0) == 0) r1 = ~r1;
      drive(r0, r1, 7'($urandom), 7'($urandom));
      if ($urandom_range(599, 0) == 0) do_reset("rst_rnd");
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
